// File: rtl/fir_tree_param.sv
// Parametrised direct-form FIR: runtime coefficient bank, full-precision pipelined adder tree,
// single round/narrow at the output. Define FIR_SATURATE_EN to clamp instead of wrap on overflow.
module fir_tree_param #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int TAPS    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coeff_addr,
  input  logic signed [COEFF_W-1:0]  coeff_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   data_out
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int D      = $clog2(TAPS);
  localparam int ACC_W  = PROD_W + D;
  localparam int LAT    = D + 2;
  localparam int LSB    = COEFF_W - 1;
  localparam int MSB    = DATA_W + COEFF_W - 2;

  localparam logic signed [ACC_W-1:0]  ROUND_K = ACC_W'(64'd1 << (COEFF_W - 2));
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Number of live nodes at a given tree level (level 0 = the products).
  function automatic int level_count(input int lvl);
    int n;
    n = TAPS;
    for (int k = 0; k < lvl; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  logic signed [COEFF_W-1:0] coeff_reg [TAPS];
  logic signed [DATA_W-1:0]  delay_reg [1:TAPS-1];
  logic signed [DATA_W-1:0]  tap       [TAPS];
  logic signed [ACC_W-1:0]   prod_next [TAPS];
  logic signed [ACC_W-1:0]   tree_reg  [D+1][TAPS];
  logic signed [ACC_W-1:0]   tree_next [1:D][TAPS];
  logic [LAT-1:0]            vld_reg;
  logic signed [DATA_W-1:0]  data_out_reg;
  logic signed [DATA_W-1:0]  out_next;
  logic signed [ACC_W-1:0]   rounded;
  logic                      unused_round;

  genvar gi;
  genvar gl;

  // Coefficient bank; an address with no matching tap simply writes nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coeff_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (coeff_wr_en && (int'(coeff_addr) == i)) begin
          coeff_reg[i] <= coeff_data;
        end
      end
    end
  end

  assign tap[0] = data_in;

  generate
    for (gi = 1; gi < TAPS; gi++) begin : g_tap
      assign tap[gi] = delay_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < TAPS; i++) begin
        delay_reg[i] <= '0;
      end
    end else if (in_valid) begin
      for (int i = 1; i < TAPS; i++) begin
        delay_reg[i] <= tap[i-1];
      end
    end
  end

  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_prod
      logic signed [PROD_W-1:0] prod_full;
      assign prod_full     = PROD_W'(tap[gi]) * PROD_W'(coeff_reg[gi]);
      assign prod_next[gi] = {{D{prod_full[PROD_W-1]}}, prod_full};
    end
  endgenerate

  // Pairwise reduction; an odd node at the end of a level is forwarded unchanged.
  generate
    for (gl = 1; gl <= D; gl++) begin : g_level
      localparam int N_IN = level_count(gl - 1);
      for (gi = 0; gi < TAPS; gi++) begin : g_node
        if (2 * gi + 1 < N_IN) begin : g_add
          assign tree_next[gl][gi] = tree_reg[gl-1][2*gi] + tree_reg[gl-1][2*gi+1];
        end else if (2 * gi < N_IN) begin : g_pass
          assign tree_next[gl][gi] = tree_reg[gl-1][2*gi];
        end else begin : g_zero
          assign tree_next[gl][gi] = '0;
        end
      end
    end
  endgenerate

  // Level 0 is the product register (held without in_valid); later levels advance every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int lv = 0; lv <= D; lv++) begin
        for (int i = 0; i < TAPS; i++) begin
          tree_reg[lv][i] <= '0;
        end
      end
    end else begin
      if (in_valid) begin
        for (int i = 0; i < TAPS; i++) begin
          tree_reg[0][i] <= prod_next[i];
        end
      end
      for (int lv = 1; lv <= D; lv++) begin
        for (int i = 0; i < TAPS; i++) begin
          tree_reg[lv][i] <= tree_next[lv][i];
        end
      end
    end
  end

  assign rounded      = tree_reg[D][0] + ROUND_K;
  assign unused_round = ^rounded;

  always_comb begin
    out_next = rounded[MSB:LSB];
`ifdef FIR_SATURATE_EN
    if (!((&rounded[ACC_W-1:MSB]) || (~|rounded[ACC_W-1:MSB]))) begin
      out_next = rounded[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_reg      <= '0;
      data_out_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[LAT-2:0], in_valid};
      if (vld_reg[LAT-2]) begin
        data_out_reg <= out_next;
      end
    end
  end

  assign out_valid = vld_reg[LAT-1];
  assign data_out  = data_out_reg;

endmodule
